// File: rtl/preproc_pkg.sv
// Shared preprocessor package.
// Holds the window state encoding and the default window geometry
// used by window_buffer and its interface.
package preproc_pkg;

  localparam int DEF_WINDOW_LENGTH = 16;
  localparam int DEF_DATA_WIDTH    = 32;

  typedef enum logic {
    FILLING = 1'b0,
    STEADY  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/window_buffer_if.sv
// Sample stream interface for window_buffer.
// master: producer/consumer side (drives sample_valid, data_in, flush;
//         observes data_in_q, data_out, out_valid, window_full, fill_count).
// slave : the window_buffer side.
interface window_buffer_if
  import preproc_pkg::*;
#(
  parameter int WINDOW_LENGTH = DEF_WINDOW_LENGTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH
);

  localparam int CW = $clog2(WINDOW_LENGTH) + 1;

  logic                         sample_valid;
  logic signed [DATA_WIDTH-1:0] data_in;
  logic                         flush;
  logic signed [DATA_WIDTH-1:0] data_in_q;
  logic signed [DATA_WIDTH-1:0] data_out;
  logic                         out_valid;
  logic                         window_full;
  logic        [CW-1:0]         fill_count;

  modport master (
    output sample_valid, data_in, flush,
    input  data_in_q, data_out, out_valid, window_full, fill_count
  );

  modport slave (
    input  sample_valid, data_in, flush,
    output data_in_q, data_out, out_valid, window_full, fill_count
  );

endinterface

// File: rtl/window_ram.sv
// Storage for the sliding window: single-port register array.
// The read port is combinational on addr, so in the cycle a write is
// issued rdata still shows the old contents (read-before-write).
// No reset: stale contents are masked by the owner while filling.
// Ports: clk, we (write enable), addr, wdata, rdata.
module window_ram #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 32,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic        [AW-1:0]         addr,
  input  logic signed [DATA_WIDTH-1:0] wdata,
  output logic signed [DATA_WIDTH-1:0] rdata
);

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/window_buffer.sv
// Sliding window delay line of WINDOW_LENGTH samples.
// Each accepted sample is registered to data_in_q and, in the same cycle,
// the sample it overwrites in the circular buffer is registered to
// data_out (zero until the window has been filled once). Both outputs are
// valid one cycle after acceptance, flagged by out_valid, and are meant to
// feed a running averager's data_in/data_out inputs directly.
// Ports: clk, rst (async, active-high), bus (window_buffer_if.slave):
//   sample_valid/data_in/flush in; data_in_q/data_out/out_valid/
//   window_full/fill_count out.
module window_buffer
  import preproc_pkg::*;
#(
  parameter int WINDOW_LENGTH = DEF_WINDOW_LENGTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  window_buffer_if.slave    bus
);

  localparam int AW = $clog2(WINDOW_LENGTH);
  localparam int CW = AW + 1;

  wb_state_e                    state, state_nxt;
  logic        [AW-1:0]         wr_ptr;
  logic        [CW-1:0]         fill_count;
  logic                         accept;
  logic                         last_fill;
  logic                         window_full;
  logic signed [DATA_WIDTH-1:0] ram_rdata;
  logic signed [DATA_WIDTH-1:0] evict_p0;
  logic signed [DATA_WIDTH-1:0] data_in_q_p1;
  logic signed [DATA_WIDTH-1:0] data_out_p1;
  logic                         vld_p1;

  // Flush wins over a coincident sample: that sample is dropped.
  assign accept    = bus.sample_valid & ~bus.flush;
  assign last_fill = (fill_count == CW'(WINDOW_LENGTH - 1));

  window_ram #(
    .DEPTH      (WINDOW_LENGTH),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (AW)
  ) u_ram (
    .clk   (clk),
    .we    (accept),
    .addr  (wr_ptr),
    .wdata (bus.data_in),
    .rdata (ram_rdata)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILLING;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = FILLING;
    end else if ((state == FILLING) && accept && last_fill) begin
      state_nxt = STEADY;
    end
  end

  // FSM: outputs. Memory is never cleared, so evictions are forced to zero
  // until every slot has been written since the last reset/flush.
  always_comb begin
    window_full = (state == STEADY);
    evict_p0    = (state == STEADY) ? ram_rdata : '0;
  end

  // Write pointer and fill level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      fill_count <= '0;
    end else if (bus.flush) begin
      wr_ptr     <= '0;
      fill_count <= '0;
    end else if (accept) begin
      wr_ptr <= wr_ptr + AW'(1);
      if (state == FILLING) begin
        fill_count <= fill_count + CW'(1);
      end
    end
  end

  // Stage p0 -> p1: registered sample, eviction and valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      data_in_q_p1 <= '0;
      data_out_p1  <= '0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        data_in_q_p1 <= bus.data_in;
        data_out_p1  <= evict_p0;
      end
    end
  end

  assign bus.data_in_q   = data_in_q_p1;
  assign bus.data_out    = data_out_p1;
  assign bus.out_valid   = vld_p1;
  assign bus.window_full = window_full;
  assign bus.fill_count  = fill_count;

endmodule
